// File: rtl/wt_dcache_rd_arb.sv
// wt_dcache_rd_arb
// Read-port arbiter for the write-through dcache memory. The load unit, PTW
// and write buffer share one data/tag read port. Two priority classes with
// round-robin inside each class, a starvation guard that forces a low-class
// grant after StarveLimit consecutive low-class losses, and blocking of all
// grants while a cacheline write/invalidate or single-word write is pending.
//
// Handshake: rd_req_i[p] is a request that stays high until rd_ack_o[p]
// (same cycle, combinational). A requester may drop without being acked.
// The response strobe rsp_vld_o/rsp_port_o follows an ack by exactly one
// cycle, aligned with cmp_tag_o for the tag compare stage.
//
// Optional feature: define WT_DCACHE_RD_ARB_STATS_EN to build the saturating
// 32-bit blocked-cycle counter on stall_cnt_o; otherwise stall_cnt_o is 0.
module wt_dcache_rd_arb #(
  parameter int NumPorts    = 3,
  parameter int TagWidth    = 44,
  parameter int IdxWidth    = 8,
  parameter int OffWidth    = 4,
  parameter int StarveLimit = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumPorts-1:0]          rd_prio_i,
  input  logic [NumPorts-1:0]          rd_req_i,
  input  logic [NumPorts*TagWidth-1:0] rd_tag_i,
  input  logic [NumPorts*IdxWidth-1:0] rd_idx_i,
  input  logic [NumPorts*OffWidth-1:0] rd_off_i,
  input  logic [NumPorts-1:0]          rd_tag_only_i,
  output logic [NumPorts-1:0]          rd_ack_o,
  input  logic                         wr_cl_vld_i,
  input  logic                         wr_req_i,
  output logic                         mem_req_o,
  output logic [IdxWidth-1:0]          mem_idx_o,
  output logic [OffWidth-1:0]          mem_off_o,
  output logic                         mem_tag_only_o,
  output logic [TagWidth-1:0]          cmp_tag_o,
  output logic                         rsp_vld_o,
  output logic [NumPorts-1:0]          rsp_port_o,
  output logic                         busy_o,
  output logic [31:0]                  stall_cnt_o
);

  localparam int PW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int SW = $clog2(StarveLimit + 1);
  localparam logic [PW-1:0] PtrRst    = PW'(NumPorts - 1);
  localparam logic [SW-1:0] StarveMax = SW'(StarveLimit);

  logic [PW-1:0]       ptr_hi_q, ptr_hi_d;
  logic [PW-1:0]       ptr_lo_q, ptr_lo_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic                rsp_vld_q, rsp_vld_d;
  logic [NumPorts-1:0] rsp_port_q, rsp_port_d;
  logic [TagWidth-1:0] cmp_tag_q, cmp_tag_d;

  logic [NumPorts-1:0] hi_req, lo_req, cls_req;
  logic [PW-1:0]       cls_ptr;
  logic                blocked, use_lo, found, grant;
  logic [PW-1:0]       win;

  // Split requests into classes and decide which class competes this cycle
  always_comb begin
    hi_req  = rd_req_i & rd_prio_i;
    lo_req  = rd_req_i & ~rd_prio_i;
    blocked = wr_cl_vld_i | wr_req_i;
    use_lo  = ((starve_q == StarveMax) && (|lo_req)) || !(|hi_req);
    cls_req = use_lo ? lo_req : hi_req;
    cls_ptr = use_lo ? ptr_lo_q : ptr_hi_q;
  end

  // Round-robin search inside the chosen class, starting after its pointer
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NumPorts; i++) begin
      int            p;
      logic [PW-1:0] cand;
      p = int'(cls_ptr) + 1 + i;
      if (p >= NumPorts) p = p - NumPorts;
      cand = PW'(p);
      if (!found && cls_req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    grant = !rst_i && !blocked && found;
  end

  // Same-cycle grant and memory-port mux; everything zero without a grant
  always_comb begin
    rd_ack_o = '0;
    for (int i = 0; i < NumPorts; i++) begin
      rd_ack_o[i] = grant && (win == PW'(i));
    end
    mem_req_o      = grant;
    mem_idx_o      = grant ? rd_idx_i[int'(win)*IdxWidth +: IdxWidth] : '0;
    mem_off_o      = grant ? rd_off_i[int'(win)*OffWidth +: OffWidth] : '0;
    mem_tag_only_o = grant ? rd_tag_only_i[win] : 1'b0;
  end

  // Next state: class pointer, compare tag, response strobe, starvation count
  always_comb begin
    ptr_hi_d   = ptr_hi_q;
    ptr_lo_d   = ptr_lo_q;
    cmp_tag_d  = cmp_tag_q;
    rsp_vld_d  = grant;
    rsp_port_d = rd_ack_o;
    starve_d   = starve_q;
    if (grant) begin
      if (use_lo) ptr_lo_d = win;
      else        ptr_hi_d = win;
      cmp_tag_d = rd_tag_i[int'(win)*TagWidth +: TagWidth];
    end
    // Blocked cycles leave the starvation count untouched
    if (!blocked) begin
      if (!(|lo_req) || (grant && use_lo)) begin
        starve_d = '0;
      end else if (grant && (starve_q != StarveMax)) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  // Arbiter state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_hi_q   <= PtrRst;
      ptr_lo_q   <= PtrRst;
      starve_q   <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_port_q <= '0;
      cmp_tag_q  <= '0;
    end else begin
      ptr_hi_q   <= ptr_hi_d;
      ptr_lo_q   <= ptr_lo_d;
      starve_q   <= starve_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_port_q <= rsp_port_d;
      cmp_tag_q  <= cmp_tag_d;
    end
  end

  assign rsp_vld_o  = rsp_vld_q;
  assign rsp_port_o = rsp_port_q;
  assign cmp_tag_o  = cmp_tag_q;
  assign busy_o     = (|rd_req_i) | rsp_vld_q;

`ifdef WT_DCACHE_RD_ARB_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count cycles where a pending read is held off by a write
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((|rd_req_i) && blocked && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Blocked-cycle counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = 32'd0;
`endif

endmodule
